clb_cfg_loader: RTL and testbench

Configuration loader for the `tt_um_gmejiamtz` configurable logic block. It accepts configuration bytes from the host over a valid/ready byte interface and serialises them, LSB first, into the CLB configuration shift chain. Once the whole chain is filled, it issues a one-cycle latch strobe that commits the new configuration. It is the write side of the CLB configuration interface, sitting between the pin-level host inputs and the CLB fabric.

---
 rtl/clb_cfg_loader.sv | 147 ++++++++++++++
 tb/tb_clb_cfg_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader
// Write side of the CLB configuration interface. Accepts bytes from the host
// over a valid/ready handshake and serialises them LSB first into the CLB
// configuration shift chain. Once CHAIN_LEN bits have been shifted, it issues
// a one-cycle commit strobe on cfg_latch.
//
// Parameters:
//   CHAIN_LEN  number of bits in the configuration chain (>= 1)
//   CNT_W      width of the total-bit counter
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a load (sampled in IDLE only)
//   abort      cancel a load in WAIT_BYTE/SHIFT; no latch is issued
//   in_data    configuration byte, LSB shifted first
//   in_valid   in_data is valid
//   in_ready   loader can accept a byte (WAIT_BYTE only)
//   cfg_bit    serial data to the chain (0 when cfg_shift is 0)
//   cfg_shift  chain shift enable, one bit per cycle
//   cfg_latch  one-cycle commit strobe
//   busy       high in any state other than IDLE
//   done       sticky completion flag, cleared by the next accepted start
module clb_cfg_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cfg_bit,
    output logic       cfg_shift,
    output logic       cfg_latch,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BYTE,
        SHIFT,
        LATCH
    } state_t;

    localparam logic [CNT_W-1:0] TOT_LAST = CNT_W'(CHAIN_LEN);

    state_t           state;
    logic [7:0]       sr;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] tot;

    logic [3:0]       bit_nxt;
    logic [CNT_W-1:0] tot_nxt;

    // Post-increment counter values; the SHIFT exit decision uses these.
    always_comb begin
        bit_nxt = bit_cnt + 4'd1;
        tot_nxt = tot + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            tot       <= '0;
            in_ready  <= 1'b0;
            cfg_bit   <= 1'b0;
            cfg_shift <= 1'b0;
            cfg_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cfg_latch <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT_BYTE;
                        done     <= 1'b0;
                        tot      <= '0;
                        bit_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                WAIT_BYTE: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (in_valid && in_ready) begin
                        // cfg_bit is registered, so bit 0 is presented right
                        // away and sr holds the remaining bits pre-shifted.
                        sr        <= {1'b0, in_data[7:1]};
                        bit_cnt   <= '0;
                        cfg_bit   <= in_data[0];
                        cfg_shift <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        state     <= IDLE;
                        cfg_shift <= 1'b0;
                        cfg_bit   <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        sr      <= sr >> 1;
                        bit_cnt <= bit_nxt;
                        tot     <= tot_nxt;
                        if (tot_nxt == TOT_LAST) begin
                            // Chain full: any unshifted upper bits of a
                            // partial final byte are dropped here.
                            state     <= LATCH;
                            cfg_shift <= 1'b0;
                            cfg_bit   <= 1'b0;
                            cfg_latch <= 1'b1;
                        end else if (bit_nxt == 4'd8) begin
                            state     <= WAIT_BYTE;
                            cfg_shift <= 1'b0;
                            cfg_bit   <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            cfg_bit <= sr[0];
                        end
                    end
                end

                LATCH: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Self-checking bench for clb_cfg_loader. Two instances: a 16-bit chain
// (whole bytes) and a 12-bit chain (partial final byte). Expected serial
// streams are the first CHAIN_LEN bits of the offered bytes, LSB first.
module tb_clb_cfg_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start, abort, in_valid;
    logic [1:0] in_ready, cfg_bit, cfg_shift, cfg_latch, busy, done;
    logic [7:0] in_data [2];

    int checks = 0;
    int errors = 0;
    int lat [2];
    bit prev_shift [2];
    bit rec [$];
    logic [7:0] bq [$];

    always #5 clk = ~clk;

    clb_cfg_loader #(.CHAIN_LEN(16)) dut16 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .cfg_bit(cfg_bit[0]), .cfg_shift(cfg_shift[0]), .cfg_latch(cfg_latch[0]),
        .busy(busy[0]), .done(done[0])
    );

    clb_cfg_loader #(.CHAIN_LEN(12)) dut12 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .cfg_bit(cfg_bit[1]), .cfg_shift(cfg_shift[1]), .cfg_latch(cfg_latch[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int len_of(input int d);
        return (d == 0) ? 16 : 12;
    endfunction

    // Observe the chain side of both instances once per cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int d = 0; d < 2; d++) begin
                if (cfg_shift[d]) rec.push_back(cfg_bit[d]);
                if (cfg_latch[d]) begin
                    lat[d]++;
                    check("latch_follows_shift", 32'(prev_shift[d]), 1);
                    check("latch_done_low", done[d], 0);
                end
                check("ready_vs_shift", in_ready[d] & cfg_shift[d], 0);
                check("bit_gated", cfg_bit[d] & ~cfg_shift[d], 0);
                check("busy_active", (in_ready[d] | cfg_shift[d] | cfg_latch[d]) & ~busy[d], 0);
                prev_shift[d] = cfg_shift[d];
            end
        end
    end

    task automatic check_stream(input int n);
        logic [31:0] got, exp;
        logic [7:0]  b;
        got = '0;
        exp = '0;
        check("stream_len", rec.size(), n);
        for (int k = 0; k < n && k < rec.size(); k++) got[k] = rec[k];
        for (int k = 0; k < n; k++) begin
            b = bq[k / 8];
            exp[k] = b[k % 8];
        end
        check("stream", got, exp);
    endtask

    // One load on instance d using the bytes in bq. gap stalls in_valid after
    // each in_ready; spam pulses start while busy; abort_byte >= 0 aborts
    // after 5 bits of that byte.
    task automatic do_load(input int d, input int gap, input bit spam, input int abort_byte);
        int len, nb, cnt, l0;
        len = len_of(d);
        nb  = (len + 7) / 8;
        rec.delete();
        l0 = lat[d];
        @(negedge clk) start[d] = 1'b1;
        @(negedge clk) start[d] = 1'b0;
        check("start_ready", in_ready[d], 1);
        check("start_busy", busy[d], 1);
        check("start_done", done[d], 0);
        for (int i = 0; i < nb; i++) begin
            for (int g = 0; g < gap; g++) begin
                start[d] = spam && (g == 1);
                @(negedge clk);
                check("stall_noshift", cfg_shift[d], 0);
            end
            start[d] = 1'b0;
            check("stall_ready", in_ready[d], 1);
            in_valid[d] = 1'b1;
            in_data[d]  = bq[i];
            @(negedge clk);
            in_valid[d] = 1'b0;
            in_data[d]  = 8'($urandom);
            check("accept_shift", cfg_shift[d], 1);
            if (i == abort_byte) begin
                repeat (4) @(negedge clk);
                abort[d] = 1'b1;
                @(negedge clk);
                abort[d] = 1'b0;
                check("abort_shift", cfg_shift[d], 0);
                check("abort_busy", busy[d], 0);
                check("abort_ready", in_ready[d], 0);
                repeat (12) @(negedge clk);
                #1;
                check("abort_nolatch", lat[d] - l0, 0);
                check("abort_done", done[d], 0);
                check_stream(8 * i + 5);
                return;
            end
            if (i < nb - 1) begin
                cnt = 0;
                while (!in_ready[d] && cnt < 40) begin
                    cnt++;
                    start[d] = spam && (cnt == 3);
                    @(negedge clk);
                end
                start[d] = 1'b0;
                check("ready_gap", cnt, 8);
            end
        end
        cnt = 0;
        while (lat[d] == l0 && cnt < 40) begin
            cnt++;
            start[d] = spam && (cnt == 2);
            @(negedge clk);
            #1;
        end
        start[d] = 1'b0;
        check("latch_seen", lat[d] - l0, 1);
        check("latch_busy", busy[d], 1);
        check("latch_done_pre", done[d], 0);
        @(negedge clk);
        #1;
        check("post_latch", cfg_latch[d], 0);
        check("post_done", done[d], 1);
        check("post_busy", busy[d], 0);
        check("post_ready", in_ready[d], 0);
        check("latch_once", lat[d] - l0, 1);
        check_stream(len);
    endtask

    task automatic abort_wait(input int d);
        @(negedge clk) start[d] = 1'b1;
        @(negedge clk) start[d] = 1'b0;
        abort[d]    = 1'b1;
        in_valid[d] = 1'b1;
        in_data[d]  = 8'($urandom);
        @(negedge clk);
        abort[d]    = 1'b0;
        in_valid[d] = 1'b0;
        check("abortw_ready", in_ready[d], 0);
        check("abortw_shift", cfg_shift[d], 0);
        check("abortw_busy", busy[d], 0);
        check("abortw_done", done[d], 0);
        repeat (3) @(negedge clk);
        check("abortw_idle", cfg_shift[d], 0);
    endtask

    task automatic reset_mid(input int d);
        int l0;
        bq.delete();
        repeat (2) bq.push_back(8'($urandom));
        @(negedge clk) start[d] = 1'b1;
        @(negedge clk) start[d] = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = bq[0];
        @(negedge clk) in_valid[d] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_shift", cfg_shift[d], 1);
        l0 = lat[d];
        #2 rst = 1'b1;
        #1;
        check("rst_outputs", {in_ready[d], cfg_bit[d], cfg_shift[d], cfg_latch[d], busy[d], done[d]}, 0);
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("rst_nolatch", lat[d] - l0, 0);
        check("rst_busy", busy[d], 0);
        check("rst_done", done[d], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d, nb, gap, ab;
        bit spam;
        rst = 1'b1;
        start = '0;
        abort = '0;
        in_valid = '0;
        in_data[0] = '0;
        in_data[1] = '0;
        lat[0] = 0;
        lat[1] = 0;
        repeat (2) @(negedge clk);
        check("reset_outs16", {in_ready[0], cfg_bit[0], cfg_shift[0], cfg_latch[0], busy[0], done[0]}, 0);
        check("reset_outs12", {in_ready[1], cfg_bit[1], cfg_shift[1], cfg_latch[1], busy[1], done[1]}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        bq = '{8'hA5, 8'h3C};
        do_load(0, 0, 1'b0, -1);
        do_load(0, 20, 1'b0, -1);
        bq = '{8'hFF, 8'h05};
        do_load(1, 0, 1'b0, -1);
        bq = '{8'h5A, 8'hC3};
        do_load(0, 0, 1'b0, 1);
        do_load(0, 0, 1'b0, -1);
        do_load(0, 3, 1'b1, -1);
        abort_wait(0);
        abort_wait(1);
        reset_mid(0);
        reset_mid(1);

        for (int it = 0; it < 24; it++) begin
            d  = int'($urandom_range(0, 1));
            nb = (len_of(d) + 7) / 8;
            bq.delete();
            for (int k = 0; k < nb; k++) bq.push_back(8'($urandom));
            gap  = int'($urandom_range(0, 6));
            spam = 1'($urandom_range(0, 1));
            ab   = -1;
            if ($urandom_range(0, 4) == 0) begin
                ab = int'($urandom_range(0, nb - 1));
                if (len_of(d) - 8 * ab < 5) ab = 0;
            end
            do_load(d, gap, spam, ab);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
